// File: rtl/mux_nx1_scan_pkg.sv
// mux_nx1_scan_pkg: mode encodings and index-width helper shared by the scan mux files
package mux_nx1_scan_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Width of an index over n values, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_nx1_scan_divider.sv
// mux_nx1_scan_divider: mod-DIV phase counter, tick flags the terminal count
module mux_nx1_scan_divider
    import mux_nx1_scan_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = idx_w(DIV);

    logic [CW-1:0] cnt;

    assign tick = cnt == CW'(DIV - 1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tick ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/mux_nx1_scan.sv
// mux_nx1_scan: registered N:1 channel mux with manual select or round-robin scan
module mux_nx1_scan
    import mux_nx1_scan_pkg::*;
#(
    parameter int               WIDTH       = 4,
    parameter int               N           = 4,
    parameter int               SCAN_DIV    = 4,
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
    localparam int              SEL_W       = idx_w(N)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] D,
    input  logic [SEL_W-1:0]   SEL,
    input  logic               MODE,
    input  logic               EN,
    output logic [WIDTH-1:0]   OUT,
    output logic [SEL_W-1:0]   SEL_ATUAL,
    output logic               VALID,
    output logic               WRAP
);

    logic [WIDTH-1:0] ch [N];
    logic [SEL_W-1:0] cur, nxt;
    logic             scan, tick, last, sel_ok;

    always_comb begin
        for (int i = 0; i < N; i++)
            ch[i] = D[i*WIDTH +: WIDTH];
    end

    assign scan   = MODE == MODE_SCAN;
    assign sel_ok = int'(SEL) < N;
    // A stale out-of-range manual index restarts scanning from channel 0.
    assign cur    = (int'(SEL_ATUAL) < N) ? SEL_ATUAL : '0;
    assign last   = int'(cur) == N - 1;
    assign nxt    = last ? '0 : cur + SEL_W'(1);

    mux_nx1_scan_divider #(.DIV(SCAN_DIV)) u_div (
        .clock (clock),
        .reset (reset),
        .clr   (!scan),
        .en    (EN),
        .tick  (tick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            OUT       <= DEFAULT_VAL;
            SEL_ATUAL <= '0;
            VALID     <= 1'b0;
            WRAP      <= 1'b0;
        end else if (!EN) begin
            WRAP      <= 1'b0;
        end else if (scan) begin
            OUT       <= ch[cur];
            VALID     <= 1'b1;
            SEL_ATUAL <= tick ? nxt : cur;
            WRAP      <= tick && last;
        end else begin
            OUT       <= sel_ok ? ch[SEL] : DEFAULT_VAL;
            VALID     <= sel_ok;
            SEL_ATUAL <= SEL;
            WRAP      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_nx1_scan.sv
// tb_mux_nx1_scan: directed vectors for a 4-channel/div-4 and a 3-channel/div-1 instance
module tb_mux_nx1_scan;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] d;
    logic [1:0]  sel, sel3;
    logic        mode, en;
    logic [3:0]  out4, out3;
    logic [1:0]  sa4, sa3;
    logic        v4, w4, v3, w3;

    int passed = 0;
    int total  = 0;

    logic [3:0] ch [4];

    typedef struct {
        logic       en;
        logic [1:0] sel;
        logic [1:0] sel3;
        logic [15:0] d;
        logic [3:0] out;
        logic [1:0] sa;
        logic       v;
        logic [3:0] out3;
        logic [1:0] sa3;
        logic       v3;
    } vec_t;

    vec_t vt [6];

    always #5 clock = ~clock;

    mux_nx1_scan #(.WIDTH(4), .N(4), .SCAN_DIV(4), .DEFAULT_VAL(4'h0)) dut (
        .clock     (clock),
        .reset     (reset),
        .D         (d),
        .SEL       (sel),
        .MODE      (mode),
        .EN        (en),
        .OUT       (out4),
        .SEL_ATUAL (sa4),
        .VALID     (v4),
        .WRAP      (w4)
    );

    mux_nx1_scan #(.WIDTH(4), .N(3), .SCAN_DIV(1), .DEFAULT_VAL(4'h0)) dut3 (
        .clock     (clock),
        .reset     (reset),
        .D         (d[11:0]),
        .SEL       (sel3),
        .MODE      (mode),
        .EN        (en),
        .OUT       (out3),
        .SEL_ATUAL (sa3),
        .VALID     (v3),
        .WRAP      (w3)
    );

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp)
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else
            passed++;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        ch = '{4'hA, 4'hB, 4'hC, 4'hD};
        vt[0] = '{1'b1, 2'd2, 2'd3, 16'hDCBA, 4'hC, 2'd2, 1'b1, 4'h0, 2'd3, 1'b0};
        vt[1] = '{1'b1, 2'd2, 2'd1, 16'hD7BA, 4'h7, 2'd2, 1'b1, 4'hB, 2'd1, 1'b1};
        vt[2] = '{1'b0, 2'd0, 2'd3, 16'hDCBA, 4'h7, 2'd2, 1'b1, 4'hB, 2'd1, 1'b1};
        vt[3] = '{1'b1, 2'd0, 2'd3, 16'hDCBA, 4'hA, 2'd0, 1'b1, 4'h0, 2'd3, 1'b0};
        vt[4] = '{1'b1, 2'd3, 2'd2, 16'hDCBA, 4'hD, 2'd3, 1'b1, 4'hC, 2'd2, 1'b1};
        vt[5] = '{1'b1, 2'd1, 2'd0, 16'hDCBA, 4'hB, 2'd1, 1'b1, 4'hA, 2'd0, 1'b1};

        reset = 1'b0; en = 1'b0; mode = 1'b0; sel = '0; sel3 = '0; d = 16'hDCBA;
        #2;
        check("rst_out", out4, 0);
        check("rst_sel", sa4, 0);
        check("rst_valid", v4, 0);
        check("rst_wrap", w4, 0);
        @(negedge clock);
        reset = 1'b1;

        // Manual mode, both instances, including the N=3 out-of-range index.
        for (int i = 0; i < 6; i++) begin
            en = vt[i].en; sel = vt[i].sel; sel3 = vt[i].sel3; d = vt[i].d;
            step();
            check($sformatf("vec%0d_out", i), out4, vt[i].out);
            check($sformatf("vec%0d_sel", i), sa4, vt[i].sa);
            check($sformatf("vec%0d_valid", i), v4, vt[i].v);
            check($sformatf("vec%0d_wrap", i), w4, 0);
            check($sformatf("vec%0d_out3", i), out3, vt[i].out3);
            check($sformatf("vec%0d_sel3", i), sa3, vt[i].sa3);
            check($sformatf("vec%0d_valid3", i), v3, vt[i].v3);
        end

        // Asynchronous reset mid-run clears without a clock edge.
        #2 reset = 1'b0;
        #1;
        check("async_out", out4, 0);
        check("async_sel", sa4, 0);
        check("async_valid", v4, 0);
        check("async_wrap", w4, 0);
        check("async_valid3", v3, 0);
        mode = 1'b1; en = 1'b1; d = 16'hDCBA; sel = '0; sel3 = '0;
        @(negedge clock);
        reset = 1'b1;

        // Scan from reset: div-4 over 4 channels, div-1 over 3 channels.
        for (int k = 1; k <= 25; k++) begin
            step();
            check($sformatf("scan%0d_sel", k), sa4, (k / 4) % 4);
            check($sformatf("scan%0d_out", k), out4, ch[((k - 1) / 4) % 4]);
            check($sformatf("scan%0d_valid", k), v4, 1);
            check($sformatf("scan%0d_wrap", k), w4, (k == 16) ? 1 : 0);
            check($sformatf("scan%0d_sel3", k), sa3, k % 3);
            check($sformatf("scan%0d_out3", k), out3, ch[(k - 1) % 3]);
            check($sformatf("scan%0d_wrap3", k), w3, (k % 3 == 0) ? 1 : 0);
        end

        // Freeze at channel 2, phase 1.
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check("hold_sel", sa4, 2);
            check("hold_out", out4, 4'hC);
            check("hold_valid", v4, 1);
            check("hold_wrap", w4, 0);
            check("hold_wrap3", w3, 0);
        end
        en = 1'b1;
        step(); check("resume1_sel", sa4, 2);
        step(); check("resume2_sel", sa4, 2);
        step(); check("resume3_sel", sa4, 3); check("resume3_out", out4, 4'hC);
        step(); check("resume4_out", out4, 4'hD);

        // Manual index 3, then scan continues from there (N=3 forced to 0).
        mode = 1'b0; sel = 2'd3; sel3 = 2'd3;
        step();
        check("man3_sel", sa4, 3);
        check("man3_out", out4, 4'hD);
        check("man3_sel3", sa3, 3);
        check("man3_valid3", v3, 0);
        check("man3_out3", out3, 0);
        mode = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            step();
            check($sformatf("sw%0d_sel", j), sa4, (j < 4) ? 3 : 0);
            check($sformatf("sw%0d_out", j), out4, (j < 5) ? 4'hD : 4'hA);
            check($sformatf("sw%0d_wrap", j), w4, (j == 4) ? 1 : 0);
            check($sformatf("sw%0d_sel3", j), sa3, j % 3);
            check($sformatf("sw%0d_out3", j), out3, ch[(j - 1) % 3]);
            check($sformatf("sw%0d_valid3", j), v3, 1);
            check($sformatf("sw%0d_wrap3", j), w3, (j % 3 == 0) ? 1 : 0);
        end

        mode = 1'b0; sel = 2'd1;
        step();
        check("back_out", out4, 4'hB);
        check("back_sel", sa4, 1);
        check("back_valid", v4, 1);
        check("back_wrap", w4, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
